// File: rtl/instr_cache_refill_ctrl.sv
// Instruction cache refill controller.
// Turns a fetch miss into one L2 line request, collects the returned beats
// (gaps allowed) into a local line buffer, then streams the whole line into
// the cache set in NB back-to-back cycles, because the set's replacement
// counter restarts whenever its replace enable drops.
module instr_cache_refill_ctrl #(
   parameter int B      = 64,
   parameter int ADDR_W = 32,
   parameter int CNT_W  = 32
) (
   input  logic              clk_i,
   input  logic              reset_n_i,
   input  logic              fetch_valid_i,
   input  logic [ADDR_W-1:0] pc_i,
   input  logic              cache_miss_i,
   input  logic              flush_i,
   output logic              l2_req_o,
   output logic [ADDR_W-1:0] l2_addr_o,
   input  logic              l2_ack_i,
   input  logic              l2_rvalid_i,
   input  logic [63:0]       l2_rdata_i,
   output logic              rep_active_o,
   output logic [63:0]       rep_word_o,
   output logic              addr_sel_o,
   output logic [ADDR_W-1:0] refill_addr_o,
   output logic              stall_o,
   output logic              flushed_o,
   output logic [CNT_W-1:0]  miss_count_o
);

   localparam int NB  = B / 8;
   localparam int OFF = $clog2(B);
   localparam int BW  = $clog2(NB);

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] REQ   = 2'd1;
   localparam logic [1:0] FILL  = 2'd2;
   localparam logic [1:0] WRITE = 2'd3;

   logic [1:0]    state;
   logic [63:0]   line_buf [NB];
   logic [BW-1:0] beat;
   logic [BW-1:0] wcnt;
   logic          flush_seen;

   logic          miss_take;
   logic          last_beat;
   logic          last_write;

   assign miss_take  = (state == IDLE) && fetch_valid_i && cache_miss_i;
   assign last_beat  = (state == FILL) && l2_rvalid_i && (beat == BW'(NB - 1));
   assign last_write = (state == WRITE) && (wcnt == BW'(NB - 1));

   // Refill sequencing: a refill always runs to completion once started
   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         state <= IDLE;
      end else begin
         case (state)
            IDLE:    if (miss_take)  state <= REQ;
            REQ:     if (l2_ack_i)   state <= FILL;
            FILL:    if (last_beat)  state <= WRITE;
            WRITE:   if (last_write) state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   // Latch the miss address and count refills, saturating at all-ones
   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         refill_addr_o <= '0;
         miss_count_o  <= '0;
      end else if (miss_take) begin
         refill_addr_o <= pc_i;
         if (miss_count_o != {CNT_W{1'b1}}) begin
            miss_count_o <= miss_count_o + 1'b1;
         end
      end
   end

   // Capture returned beats in arrival order; beats before the ack are ignored
   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         beat <= '0;
         for (int i = 0; i < NB; i++) begin
            line_buf[i] <= '0;
         end
      end else if ((state == REQ) && l2_ack_i) begin
         beat <= '0;
      end else if ((state == FILL) && l2_rvalid_i) begin
         line_buf[beat] <= l2_rdata_i;
         beat           <= beat + 1'b1;
      end
   end

   // Walk the buffer one beat per cycle while writing the line into the set
   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         wcnt <= '0;
      end else if (last_beat) begin
         wcnt <= '0;
      end else if (state == WRITE) begin
         wcnt <= wcnt + 1'b1;
      end
   end

   // Remember a redirect seen mid-refill so it can be reported at the end
   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         flush_seen <= 1'b0;
      end else if (last_write) begin
         flush_seen <= 1'b0;
      end else if ((state != IDLE) && flush_i) begin
         flush_seen <= 1'b1;
      end
   end

   // Output decode from the current state
   always_comb begin
      l2_req_o     = 1'b0;
      l2_addr_o    = '0;
      rep_active_o = 1'b0;
      rep_word_o   = '0;
      addr_sel_o   = 1'b0;
      stall_o      = 1'b0;
      flushed_o    = 1'b0;
      case (state)
         IDLE: begin
            stall_o = fetch_valid_i && cache_miss_i;
         end
         REQ: begin
            l2_req_o   = 1'b1;
            l2_addr_o  = {refill_addr_o[ADDR_W-1:OFF], {OFF{1'b0}}};
            addr_sel_o = 1'b1;
            stall_o    = 1'b1;
         end
         FILL: begin
            addr_sel_o = 1'b1;
            stall_o    = 1'b1;
         end
         WRITE: begin
            rep_active_o = 1'b1;
            rep_word_o   = line_buf[wcnt];
            addr_sel_o   = 1'b1;
            stall_o      = 1'b1;
            flushed_o    = last_write && (flush_seen || flush_i);
         end
         default: begin
            stall_o = 1'b0;
         end
      endcase
   end

endmodule

// File: tb/tb_instr_cache_refill_ctrl.sv
// Directed self-checking bench for the instruction cache refill controller.
// Inputs are driven just after the falling edge and outputs are sampled 1ns
// later, well away from the rising edge the design acts on.
module tb_instr_cache_refill_ctrl;

   logic        clk_i = 1'b0;
   logic        reset_n_i;
   logic        fetch_valid_i;
   logic [31:0] pc_i;
   logic        cache_miss_i;
   logic        flush_i;
   logic        l2_req_o;
   logic [31:0] l2_addr_o;
   logic        l2_ack_i;
   logic        l2_rvalid_i;
   logic [63:0] l2_rdata_i;
   logic        rep_active_o;
   logic [63:0] rep_word_o;
   logic        addr_sel_o;
   logic [31:0] refill_addr_o;
   logic        stall_o;
   logic        flushed_o;
   logic [31:0] miss_count_o;

   int checkCount = 0;
   int failCount  = 0;

   instr_cache_refill_ctrl #(.B(64), .ADDR_W(32), .CNT_W(32)) dut (
      .clk_i         (clk_i),
      .reset_n_i     (reset_n_i),
      .fetch_valid_i (fetch_valid_i),
      .pc_i          (pc_i),
      .cache_miss_i  (cache_miss_i),
      .flush_i       (flush_i),
      .l2_req_o      (l2_req_o),
      .l2_addr_o     (l2_addr_o),
      .l2_ack_i      (l2_ack_i),
      .l2_rvalid_i   (l2_rvalid_i),
      .l2_rdata_i    (l2_rdata_i),
      .rep_active_o  (rep_active_o),
      .rep_word_o    (rep_word_o),
      .addr_sel_o    (addr_sel_o),
      .refill_addr_o (refill_addr_o),
      .stall_o       (stall_o),
      .flushed_o     (flushed_o),
      .miss_count_o  (miss_count_o)
   );

   // Free-running 10ns clock
   always #5 clk_i = ~clk_i;

   task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
      checkCount++;
      if (actual !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: got %h expected %h at %0t", tag, actual, expected, $time);
      end
   endtask

   task automatic applyStimulus(input logic fv, input logic [31:0] pc, input logic miss,
                                input logic flush, input logic ack, input logic rvalid,
                                input logic [63:0] rdata);
      fetch_valid_i = fv;
      pc_i          = pc;
      cache_miss_i  = miss;
      flush_i       = flush;
      l2_ack_i      = ack;
      l2_rvalid_i   = rvalid;
      l2_rdata_i    = rdata;
   endtask

   task automatic checkAllZero(input string tag);
      checkOutput({tag, "_l2_req"},     64'(l2_req_o),      64'd0);
      checkOutput({tag, "_l2_addr"},    64'(l2_addr_o),     64'd0);
      checkOutput({tag, "_rep_active"}, 64'(rep_active_o),  64'd0);
      checkOutput({tag, "_rep_word"},   rep_word_o,         64'd0);
      checkOutput({tag, "_addr_sel"},   64'(addr_sel_o),    64'd0);
      checkOutput({tag, "_refill_addr"},64'(refill_addr_o), 64'd0);
      checkOutput({tag, "_stall"},      64'(stall_o),       64'd0);
      checkOutput({tag, "_flushed"},    64'(flushed_o),     64'd0);
      checkOutput({tag, "_miss_count"}, 64'(miss_count_o),  64'd0);
   endtask

   task automatic doReset();
      @(negedge clk_i);
      applyStimulus(1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 64'd0);
      reset_n_i = 1'b0;
      #1;
      checkAllZero("reset");
      @(negedge clk_i);
      reset_n_i = 1'b1;
   endtask

   // One complete refill: IDLE miss cycle, REQ (ackDelay extra cycles, junk
   // rvalid beats that must be ignored), FILL with optional gaps and a flush
   // pulse on fill cycle flushAt, then NB WRITE cycles checked word by word.
   task automatic doRefill(input string tag, input logic [31:0] pc, input int ackDelay,
                           input bit gaps, input int flushAt, input logic [31:0] expCount,
                           input logic [63:0] base);
      logic [63:0] words [8];
      logic [31:0] aligned;
      int fillCyc;
      aligned = {pc[31:6], 6'd0};
      for (int i = 0; i < 8; i++) words[i] = base * 64'(i + 1);

      @(negedge clk_i);
      applyStimulus(1'b1, pc, 1'b1, 1'b0, 1'b0, 1'b0, 64'd0);
      #1;
      checkOutput({tag, "_idle_stall"},    64'(stall_o),      64'd1);
      checkOutput({tag, "_idle_addr_sel"}, 64'(addr_sel_o),   64'd0);
      checkOutput({tag, "_idle_req"},      64'(l2_req_o),     64'd0);
      checkOutput({tag, "_idle_count"},    64'(miss_count_o), 64'(expCount - 1));

      for (int r = 0; r <= ackDelay; r++) begin
         @(negedge clk_i);
         applyStimulus(1'b1, 32'hFFFF_FF00, 1'b1, 1'b0, (r == ackDelay), 1'b1, 64'hDEAD_BEEF_0000_0000);
         #1;
         checkOutput({tag, "_req"},       64'(l2_req_o),      64'd1);
         checkOutput({tag, "_req_addr"},  64'(l2_addr_o),     64'(aligned));
         checkOutput({tag, "_req_stall"}, 64'(stall_o),       64'd1);
         checkOutput({tag, "_req_sel"},   64'(addr_sel_o),    64'd1);
         checkOutput({tag, "_req_raddr"}, 64'(refill_addr_o), 64'(pc));
         checkOutput({tag, "_req_count"}, 64'(miss_count_o),  64'(expCount));
      end

      fillCyc = 0;
      for (int i = 0; i < 8; i++) begin
         int nGap;
         nGap = (gaps && i > 0) ? (i % 3) + 1 : 0;
         for (int g = 0; g < nGap; g++) begin
            @(negedge clk_i);
            applyStimulus(1'b0, 32'd0, 1'b0, (fillCyc == flushAt), 1'b0, 1'b0, 64'hBAD);
            #1;
            checkOutput({tag, "_gap_req"},   64'(l2_req_o),     64'd0);
            checkOutput({tag, "_gap_rep"},   64'(rep_active_o), 64'd0);
            checkOutput({tag, "_gap_stall"}, 64'(stall_o),      64'd1);
            fillCyc++;
         end
         @(negedge clk_i);
         applyStimulus(1'b0, 32'd0, 1'b0, (fillCyc == flushAt), 1'b0, 1'b1, words[i]);
         #1;
         checkOutput({tag, "_fill_req"}, 64'(l2_req_o),     64'd0);
         checkOutput({tag, "_fill_rep"}, 64'(rep_active_o), 64'd0);
         checkOutput({tag, "_fill_sel"}, 64'(addr_sel_o),   64'd1);
         fillCyc++;
      end

      for (int w = 0; w < 8; w++) begin
         @(negedge clk_i);
         applyStimulus(1'b1, pc, 1'b1, 1'b0, 1'b0, 1'b0, 64'd0);
         #1;
         checkOutput({tag, "_wr_active"}, 64'(rep_active_o), 64'd1);
         checkOutput({tag, "_wr_word"},   rep_word_o,        words[w]);
         checkOutput({tag, "_wr_stall"},  64'(stall_o),      64'd1);
         checkOutput({tag, "_wr_flushed"},64'(flushed_o),    64'((w == 7) && (flushAt >= 0)));
         checkOutput({tag, "_wr_count"},  64'(miss_count_o), 64'(expCount));
      end
   endtask

   // IDLE cycle after a refill: the set now hits, so fetch resumes
   task automatic checkResume(input string tag, input logic [31:0] expCount);
      @(negedge clk_i);
      applyStimulus(1'b1, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 64'd0);
      #1;
      checkOutput({tag, "_res_stall"},   64'(stall_o),      64'd0);
      checkOutput({tag, "_res_rep"},     64'(rep_active_o), 64'd0);
      checkOutput({tag, "_res_word"},    rep_word_o,        64'd0);
      checkOutput({tag, "_res_sel"},     64'(addr_sel_o),   64'd0);
      checkOutput({tag, "_res_flushed"}, 64'(flushed_o),    64'd0);
      checkOutput({tag, "_res_count"},   64'(miss_count_o), 64'(expCount));
   endtask

   // Directed scenario sequence
   initial begin
      reset_n_i = 1'b1;
      applyStimulus(1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 64'd0);

      doReset();
      doRefill("t1", 32'h0000_1044, 0, 1'b0, -1, 32'd1, 64'h11);
      checkResume("t1", 32'd1);

      doRefill("t2", 32'h0000_2F08, 5, 1'b0, -1, 32'd2, 64'h0101_0000_0000_0003);
      checkResume("t2", 32'd2);

      doRefill("t3", 32'h0001_00BC, 0, 1'b1, -1, 32'd3, 64'h0000_00AA_0000_0005);
      checkResume("t3", 32'd3);

      doReset();
      doRefill("t4", 32'h0000_3000, 0, 1'b1, 4, 32'd1, 64'h77);
      checkResume("t4", 32'd1);

      doReset();
      doRefill("t6a", 32'h0000_4010, 0, 1'b0, -1, 32'd1, 64'h21);
      doRefill("t6b", 32'h0000_5038, 1, 1'b0, -1, 32'd2, 64'h43);
      checkResume("t6", 32'd2);

      doReset();
      @(negedge clk_i);
      applyStimulus(1'b1, 32'h0000_6000, 1'b1, 1'b0, 1'b0, 1'b0, 64'd0);
      @(negedge clk_i);
      applyStimulus(1'b0, 32'd0, 1'b0, 1'b0, 1'b1, 1'b0, 64'd0);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk_i);
         applyStimulus(1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b1, 64'h0BAD_0000 + 64'(i));
      end
      @(negedge clk_i);
      applyStimulus(1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b1, 64'h0BAD_0003);
      reset_n_i = 1'b0;
      #1;
      checkAllZero("t5");
      @(negedge clk_i);
      applyStimulus(1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 64'd0);
      reset_n_i = 1'b1;
      doRefill("t5", 32'h0000_7020, 0, 1'b0, -1, 32'd1, 64'h99);
      checkResume("t5", 32'd1);

      $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
      $finish;
   end

endmodule
